// File: rtl/fetch_queue.sv
// fetch_queue: dual-issue in-order instruction buffer between fetch and decode.
// Accepts two {pc, inst} pairs per cycle, pops up to two, and flushes on redirect.
module fetch_queue #(
   parameter int          DEPTH    = 8,
   parameter int          PTR_W    = $clog2(DEPTH),
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid_A,
   input  logic [31:0]      in_inst_A,
   input  logic [31:0]      in_pc_A,
   input  logic             in_valid_B,
   input  logic [31:0]      in_inst_B,
   input  logic [31:0]      in_pc_B,
   output logic             in_ready,
   input  logic             deq_ready,
   output logic [31:0]      instA,
   output logic [31:0]      pcA,
   output logic             validA,
   output logic [31:0]      instB,
   output logic [31:0]      pcB,
   output logic             validB,
   output logic [PTR_W:0]   count
);

   localparam int CW = PTR_W + 1;

   logic [63:0]      mem_q [DEPTH];
   logic [63:0]      mem_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W-1:0] head_p1, tail_p1;
   logic [CW-1:0]    count_q, count_d;
   logic [CW-1:0]    push_n, pop_n;
   logic             push;

   // Space for a full pair is judged from registered occupancy only, so
   // a same-cycle pop never opens room for a push.
   assign in_ready = count_q <= CW'(DEPTH - 2);
   assign count    = count_q;
   assign head_p1  = head_q + PTR_W'(1);
   assign tail_p1  = tail_q + PTR_W'(1);

   // Present the two oldest entries; empty slots drive a NOP at pc 0.
   always_comb begin
      validA = count_q != '0;
      validB = count_q > CW'(1);
      instA  = NOP_INST;
      pcA    = '0;
      instB  = NOP_INST;
      pcB    = '0;
      if (validA) begin
         pcA   = mem_q[head_q][63:32];
         instA = mem_q[head_q][31:0];
      end
      if (validB) begin
         pcB   = mem_q[head_p1][63:32];
         instB = mem_q[head_p1][31:0];
      end
   end

   // Next-state for pointers, occupancy and storage; flush wins over push/pop.
   always_comb begin
      push   = in_ready && in_valid_A && !flush;
      push_n = '0;
      if (push) begin
         push_n = in_valid_B ? CW'(2) : CW'(1);
      end
      pop_n = '0;
      if (deq_ready) begin
         pop_n = (count_q > CW'(1)) ? CW'(2) : count_q;
      end
      mem_d   = mem_q;
      head_d  = head_q + pop_n[PTR_W-1:0];
      tail_d  = tail_q + push_n[PTR_W-1:0];
      count_d = count_q + push_n - pop_n;
      if (push) begin
         mem_d[tail_q] = {in_pc_A, in_inst_A};
         if (in_valid_B) begin
            mem_d[tail_p1] = {in_pc_B, in_inst_B};
         end
      end
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   // Pointer and occupancy registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage; contents are meaningless outside the head..tail window.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Dual-issue instruction queue between instruction fetch and `decoder`.
- Accepts up to two fetched {pc, inst} pairs per cycle, buffers them in order, and presents the two oldest entries as instA/pcA and instB/pcB.
- Pops 0, 1 or 2 entries per cycle, depending on downstream readiness and occupancy.
- A flush input discards all contents on branch redirect.

Parameters:
- DEPTH, 8, number of entries; power of two, ≥4.
- PTR_W, 3, log2(DEPTH); pointer width.
- NOP_INST, 32'h00000013, instruction value driven on an output slot whose valid is low.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous active-high reset.
- flush  input  1  discard all entries this cycle.
- in_valid_A  input  1  fetch slot A carries an instruction.
- in_inst_A  input  32  slot A instruction.
- in_pc_A  input  32  slot A PC.
- in_valid_B  input  1  fetch slot B carries an instruction; only legal with in_valid_A=1.
- in_inst_B  input  32  slot B instruction.
- in_pc_B  input  32  slot B PC.
- in_ready  output  1  queue can accept two entries this cycle.
- deq_ready  input  1  decoder accepts the presented slots this cycle.
- instA  output  32  oldest entry instruction.
- pcA  output  32  oldest entry PC.
- validA  output  1  instA/pcA valid.
- instB  output  32  second-oldest entry instruction.
- pcB  output  32  second-oldest entry PC.
- validB  output  1  instB/pcB valid.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:

Storage and pointers:
- DEPTH-entry circular buffer of {pc, inst}, 64 bits per entry.
- Head and tail pointers are PTR_W bits and wrap modulo DEPTH.
- count is a separate registered counter.

Reset (rst=1 at a clock edge):
- head=0, tail=0, count=0.
- validA=0, validB=0.
- instA=instB=NOP_INST, pcA=pcB=0.
- in_ready=1.
- Storage contents are don't-care.
- Reset overrides flush, enqueue and dequeue in the same cycle.

Output slots (combinational from registered state):
- validA = (count≥1); validB = (count≥2).
- instA/pcA = entry[head]; instB/pcB = entry[head+1 mod DEPTH].
- A slot with valid=0 drives inst=NOP_INST, pc=0.

Enqueue:
- in_ready = (DEPTH − count ≥ 2), from registered count only; no same-cycle bypass of dequeue space.
- Enqueue occurs when in_ready=1 and in_valid_A=1.
- Writes A at tail, then B at tail+1 if in_valid_B.
- tail advances by 1 or 2.
- If in_ready=0, inputs are ignored; fetch must hold them.
- in_valid_B=1 with in_valid_A=0 is illegal; B is ignored.

Dequeue:
- When deq_ready=1: pop_n = min(count, 2); head advances by pop_n.
- When deq_ready=0: pop_n = 0.
- Dequeue on empty is a no-op.

Count update:
- count_next = count + push_n − pop_n, where push_n ∈ {0,1,2}.
- Simultaneous push and pop in one cycle is legal and updates correctly.

Ordering:
- A is older than B on both input and output.
- Program order is preserved across wrap-around.

Latency:
- An entry written at edge N is visible on the output slots after edge N (same cycle as the updated count).
- There is no input-to-output combinational path.

Flush (rst=0, flush=1):
- Next cycle: head=tail=0, count=0.
- Same-cycle enqueue is discarded; same-cycle dequeue has no effect.
- Outputs are invalid in the cycle after flush.

Full condition:
- count=DEPTH−1 gives in_ready=0, even if a dequeue happens the same cycle.

Test Plan:
- Reset/empty: hold rst=1 for 2 cycles, then release → validA=validB=0, instA=32'h00000013, pcA=0, count=0, in_ready=1.
- Dual enqueue, then dequeue:
  - Push A={pc 0x10, inst 0x00000013} and B={pc 0x14, inst 0x00500093} with deq_ready=0 → next cycle validA=validB=1, pcA=0x10, pcB=0x14, count=2.
  - Then deq_ready=1 for 1 cycle → count=0.
- Single-entry pop: only A valid (pc 0x20, inst 0xABCD1234), then deq_ready=1 → validA=1, validB=0, instB=NOP; one cycle later count=0.
- Full/backpressure:
  - Push 4 pairs (pc 0x40..0x5C) with deq_ready=0 → count=8, in_ready=0.
  - Further push of pc 0x60 is ignored; count stays 8.
  - Set deq_ready=1 → pcA=0x40, then 0x48, … in order.
- Wrap-around: stream 12 pairs with deq_ready=1 every other cycle → output PC sequence strictly +4 with no gaps or duplicates across the pointer wrap.
- Flush and reset priority:
  - With count=6, flush=1 plus a simultaneous push → next cycle count=0, validA=0.
  - rst=1 and flush=1 together with count=4 → reset values.
